// File: rtl/interrupt_sequencer.sv
// Interrupt sequencer: arbitrates reset, NMI, IRQ and software BRK and drives the shared BRK microsequence controls.
// Build option: define NMI_HIJACK_EN to let an NMI arriving during an IRQ/BRK sequence take over its vector fetch.
module interrupt_sequencer #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk_ph1,
  input  logic       rst,
  input  logic       nmi_n,
  input  logic       irq_n,
  input  logic       i_flag,
  input  logic [7:0] PD,
  input  logic [2:0] cycle,
  input  logic [2:0] next_cycle,
  input  logic       vec_fetch,
  output logic       int_flag,
  output logic [7:0] vec_addr_lo,
  output logic       b_push,
  output logic       wr_suppress,
  output logic       pc_inc_inh,
  output logic       seq_active
);

  localparam logic [7:0] VEC_RESET = 8'hFC;
  localparam logic [7:0] VEC_NMI   = 8'hFA;
  localparam logic [7:0] VEC_IRQ   = 8'hFE;

  typedef enum logic {ST_IDLE, ST_SEQ} state_t;
  typedef enum logic [1:0] {SRC_RESET, SRC_NMI, SRC_IRQ, SRC_BRK} src_t;

  state_t                 r_state;
  src_t                   r_src;
  logic [SYNC_STAGES-1:0] r_nmi_sync;
  logic [SYNC_STAGES-1:0] r_irq_sync;
  logic                   r_nmi_prev;
  logic                   r_nmi_pend;
  logic                   r_reset_pend;
  logic                   r_int_flag;
  logic [7:0]             r_vec;
  logic                   r_b_push;
  logic                   r_wr_sup;
  logic                   r_pc_inh;
  logic                   r_seq_active;

  logic       w_nmi_s;
  logic       w_irq_s;
  logic       w_nmi_edge;
  logic       w_irq_req;
  logic       w_vf;
  logic       w_t1;
  logic       w_sel_nmi;
  logic       w_enter;
  logic       w_hijack;
  src_t       w_src_sel;
  logic [7:0] w_vec_sel;

  generate
    if (SYNC_STAGES > 1) begin : g_sync_n
      always_ff @(posedge clk_ph1) begin
        if (!rst) begin
          r_nmi_sync <= '1;
          r_irq_sync <= '1;
        end else begin
          r_nmi_sync <= {r_nmi_sync[SYNC_STAGES-2:0], nmi_n};
          r_irq_sync <= {r_irq_sync[SYNC_STAGES-2:0], irq_n};
        end
      end
    end else begin : g_sync_1
      always_ff @(posedge clk_ph1) begin
        if (!rst) begin
          r_nmi_sync <= '1;
          r_irq_sync <= '1;
        end else begin
          r_nmi_sync <= nmi_n;
          r_irq_sync <= irq_n;
        end
      end
    end
  endgenerate

  assign w_nmi_s    = r_nmi_sync[SYNC_STAGES-1];
  assign w_irq_s    = r_irq_sync[SYNC_STAGES-1];
  assign w_nmi_edge = r_nmi_prev & ~w_nmi_s;
  assign w_irq_req  = ~w_irq_s & ~i_flag;
  // Vector-fetch strobes in T0/T1 are decode artefacts and must not end a sequence.
  assign w_vf       = vec_fetch & (cycle > 3'd1);
  assign w_t1       = (next_cycle == 3'd1);
  assign w_sel_nmi  = (r_state == ST_SEQ) && (r_vec == VEC_NMI);
  assign w_enter    = (r_state == ST_IDLE) && w_t1 && (r_int_flag || (PD == 8'h00));

`ifdef NMI_HIJACK_EN
  assign w_hijack = (r_state == ST_SEQ) && ((r_src == SRC_IRQ) || (r_src == SRC_BRK)) &&
                    r_nmi_pend && !w_vf;
`else
  assign w_hijack = 1'b0;
`endif

  always_comb begin
    w_src_sel = SRC_BRK;
    w_vec_sel = VEC_IRQ;
    if (r_reset_pend) begin
      w_src_sel = SRC_RESET;
      w_vec_sel = VEC_RESET;
    end else if (r_int_flag && r_nmi_pend) begin
      w_src_sel = SRC_NMI;
      w_vec_sel = VEC_NMI;
    end else if (r_int_flag) begin
      w_src_sel = SRC_IRQ;
    end
  end

  always_ff @(posedge clk_ph1) begin
    if (!rst) begin
      r_nmi_prev   <= 1'b1;
      r_nmi_pend   <= 1'b0;
      r_reset_pend <= 1'b1;
      r_int_flag   <= 1'b1;
      r_state      <= ST_IDLE;
      r_src        <= SRC_RESET;
      r_vec        <= VEC_RESET;
      r_b_push     <= 1'b0;
      r_wr_sup     <= 1'b1;
      r_pc_inh     <= 1'b1;
      r_seq_active <= 1'b0;
    end else begin
      r_nmi_prev <= w_nmi_s;
      // A fresh edge outranks the clear, so an NMI landing on its own vector fetch is not lost.
      if (w_nmi_edge) begin
        r_nmi_pend <= 1'b1;
      end else if (w_vf && w_sel_nmi) begin
        r_nmi_pend <= 1'b0;
      end

      if (r_state == ST_IDLE) begin
        if (!w_t1) begin
          r_int_flag <= r_reset_pend | r_nmi_pend | w_irq_req;
        end else if (w_enter) begin
          r_state      <= ST_SEQ;
          r_src        <= w_src_sel;
          r_int_flag   <= 1'b0;
          r_vec        <= w_vec_sel;
          r_b_push     <= (w_src_sel == SRC_BRK);
          r_wr_sup     <= (w_src_sel == SRC_RESET);
          r_pc_inh     <= (w_src_sel != SRC_BRK);
          r_seq_active <= 1'b1;
        end
      end else begin
        r_int_flag <= 1'b0;
        if (w_vf) begin
          r_state      <= ST_IDLE;
          r_vec        <= VEC_IRQ;
          r_b_push     <= 1'b0;
          r_wr_sup     <= 1'b0;
          r_pc_inh     <= 1'b0;
          r_seq_active <= 1'b0;
          if (r_src == SRC_RESET) begin
            r_reset_pend <= 1'b0;
          end
        end else if (w_hijack) begin
          r_vec <= VEC_NMI;
        end
      end
    end
  end

  assign int_flag    = r_int_flag;
  assign vec_addr_lo = r_vec;
  assign b_push      = r_b_push;
  assign wr_suppress = r_wr_sup;
  assign pc_inc_inh  = r_pc_inh;
  assign seq_active  = r_seq_active;

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Scoreboard bench for interrupt_sequencer: an instruction-level cycle-controller driver feeds a queue-based monitor.
// Honours NMI_HIJACK_EN the same way as the design build.
module tb_interrupt_sequencer;
  logic       clk_ph1 = 1'b0;
  logic       rst = 1'b0;
  logic       nmi_n = 1'b1;
  logic       irq_n = 1'b1;
  logic       i_flag = 1'b1;
  logic [7:0] PD = 8'hEA;
  logic [2:0] cycle = 3'd1;
  logic [2:0] next_cycle = 3'd2;
  logic       vec_fetch = 1'b0;
  logic       int_flag;
  logic [7:0] vec_addr_lo;
  logic       b_push;
  logic       wr_suppress;
  logic       pc_inc_inh;
  logic       seq_active;

  interrupt_sequencer #(.SYNC_STAGES(2)) dut (
    .clk_ph1(clk_ph1), .rst(rst), .nmi_n(nmi_n), .irq_n(irq_n), .i_flag(i_flag),
    .PD(PD), .cycle(cycle), .next_cycle(next_cycle), .vec_fetch(vec_fetch),
    .int_flag(int_flag), .vec_addr_lo(vec_addr_lo), .b_push(b_push),
    .wr_suppress(wr_suppress), .pc_inc_inh(pc_inc_inh), .seq_active(seq_active)
  );

  always #5 clk_ph1 = ~clk_ph1;

  typedef enum int {S_RESET, S_NMI, S_IRQ, S_BRK} src_e;
  typedef struct packed {logic [7:0] vec; logic b; logic wr; logic pc;} seq_exp_t;
  typedef struct packed {logic flag; logic idle_chk;} bnd_exp_t;

  seq_exp_t seq_q[$];
  bnd_exp_t bnd_q[$];
  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;
  int n_seq = 0;

  // Reference state: what the sequencer has latched, in instruction-level terms.
  bit m_reset_pend;
  bit m_nmi_pend;
  bit m_nmi_lvl;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input logic [2:0] c, input logic [2:0] nc, input logic [7:0] pd, input logic vf);
    cycle = c;
    next_cycle = nc;
    PD = pd;
    vec_fetch = vf;
    @(posedge clk_ph1);
    #1;
  endtask

  task automatic run_seq(input src_e src, input bit nmi_fall);
    seq_exp_t e;
    e.vec = (src == S_RESET) ? 8'hFC : (src == S_NMI) ? 8'hFA : 8'hFE;
    e.b   = (src == S_BRK);
    e.wr  = (src == S_RESET);
    e.pc  = (src != S_BRK);
    if (src == S_RESET) m_reset_pend = 1'b0;
    if (src == S_NMI) m_nmi_pend = 1'b0;
    if (nmi_fall) begin
      m_nmi_lvl = 1'b0;
`ifdef NMI_HIJACK_EN
      if (src == S_IRQ || src == S_BRK) e.vec = 8'hFA;
      else m_nmi_pend = 1'b1;
`else
      m_nmi_pend = 1'b1;
`endif
    end
    seq_q.push_back(e);
    bnd_q.push_back('{flag: 1'b0, idle_chk: 1'b1});
    $display("SEQ %0d src=%s exp vec=%02h b=%0d wr=%0d pc=%0d", n_seq, src.name(), e.vec, e.b, e.wr, e.pc);
    n_seq++;
    for (int c = 1; c <= 7; c++) begin
      if (c == 2 && nmi_fall) nmi_n = 1'b0;
      tick(3'(c), (c == 7) ? 3'd1 : 3'(c + 1),
           (c == 7) ? 8'($urandom_range(1, 255)) : 8'($urandom),
           (c == 6) || (c == 1 && $urandom_range(0, 1) == 1));
    end
  endtask

  // One normal instruction of length len; requests applied in T1, optional late irq/i change in the last cycle.
  task automatic do_instr(input int len, input logic [7:0] pd, input bit nmi_v, input bit irq_v, input bit if_v,
                          input bit late, input bit late_irq, input bit late_if, input bit hij);
    bit flag;
    bit go;
    src_e src;
    if (m_nmi_lvl && !nmi_v) m_nmi_pend = 1'b1;
    m_nmi_lvl = nmi_v;
    nmi_n = nmi_v;
    irq_n = irq_v;
    i_flag = if_v;
    flag = m_reset_pend | m_nmi_pend | (!irq_v && !if_v);
    go = flag || (pd == 8'h00);
    src = m_reset_pend ? S_RESET : m_nmi_pend ? S_NMI : flag ? S_IRQ : S_BRK;
    bnd_q.push_back('{flag: flag, idle_chk: 1'b0});
    $display("INSTR len=%0d pd=%02h nmi_n=%0d irq_n=%0d i=%0d late=%0d exp int_flag=%0d", len, pd, nmi_v, irq_v,
             if_v, late, flag);
    for (int c = 1; c <= len; c++) begin
      if (c == len && late) begin
        irq_n = late_irq;
        i_flag = late_if;
      end
      tick(3'(c), (c == len) ? 3'd1 : 3'(c + 1), (c == len) ? pd : 8'($urandom),
           (c == 1) ? 1'($urandom) : 1'b0);
    end
    if (go) run_seq(src, hij);
  endtask

  always @(negedge clk_ph1) begin
    if (mon_en) begin
      if (vec_fetch && cycle > 3'd1) begin
        if (seq_q.size() == 0) begin
          check("seq_unexpected", seq_active, 0);
        end else begin
          seq_exp_t e;
          e = seq_q.pop_front();
          check("vec_addr_lo", vec_addr_lo, e.vec);
          check("b_push", b_push, e.b);
          check("wr_suppress", wr_suppress, e.wr);
          check("pc_inc_inh", pc_inc_inh, e.pc);
          check("seq_active", seq_active, 1);
        end
      end
      if (next_cycle == 3'd1) begin
        if (bnd_q.size() == 0) begin
          check("bnd_unexpected", bnd_q.size(), 1);
        end else begin
          bnd_exp_t b;
          b = bnd_q.pop_front();
          check("int_flag_t1", int_flag, b.flag);
          check("seq_active_t1", seq_active, 0);
          if (b.idle_chk) begin
            check("idle_vec", vec_addr_lo, 8'hFE);
            check("idle_b", b_push, 0);
            check("idle_wr", wr_suppress, 0);
            check("idle_pc", pc_inc_inh, 0);
          end
        end
      end
    end
  end

  initial begin
    bit nmi_cur;
    rst = 1'b0;
    repeat (2) @(posedge clk_ph1);
    #1;
    check("rst_int_flag", int_flag, 1);
    check("rst_vec", vec_addr_lo, 8'hFC);
    check("rst_b_push", b_push, 0);
    check("rst_wr_sup", wr_suppress, 1);
    check("rst_pc_inh", pc_inc_inh, 1);
    check("rst_seq_active", seq_active, 0);
    rst = 1'b1;
    m_reset_pend = 1'b1;
    m_nmi_pend = 1'b0;
    m_nmi_lvl = 1'b1;
    mon_en = 1'b1;
    // reset sequence, then quiet
    do_instr(5, 8'hEA, 1, 1, 1, 0, 1, 1, 0);
    do_instr(5, 8'hEA, 1, 1, 1, 0, 1, 1, 0);
    // masked IRQ, then unmasked with a BRK opcode pending (hardware wins)
    for (int k = 0; k < 3; k++) do_instr(6, 8'hEA, 1, 0, 1, 0, 1, 1, 0);
    do_instr(5, 8'h00, 1, 0, 0, 0, 1, 1, 0);
    do_instr(5, 8'hEA, 1, 1, 1, 0, 1, 1, 0);
    // NMI held low for many cycles: one sequence only
    do_instr(5, 8'hEA, 0, 1, 1, 0, 1, 1, 0);
    for (int k = 0; k < 3; k++) do_instr(7, 8'hEA, 0, 1, 1, 0, 1, 1, 0);
    do_instr(5, 8'hEA, 1, 1, 1, 0, 1, 1, 0);
    // software BRK
    do_instr(5, 8'h00, 1, 1, 1, 0, 1, 1, 0);
    // NMI and IRQ together, IRQ follows
    do_instr(5, 8'hEA, 0, 0, 0, 0, 1, 1, 0);
    do_instr(5, 8'hEA, 0, 0, 0, 0, 1, 1, 0);
    do_instr(5, 8'hEA, 1, 1, 1, 0, 1, 1, 0);
    // NMI arriving inside a BRK sequence
    do_instr(5, 8'h00, 1, 1, 1, 0, 1, 1, 1);
    do_instr(5, 8'hEA, 0, 1, 1, 0, 1, 1, 0);
    do_instr(5, 8'hEA, 1, 1, 1, 0, 1, 1, 0);
    // IRQ dropped after the last poll still runs; IRQ raised after it waits
    do_instr(5, 8'hEA, 1, 0, 0, 1, 1, 0, 0);
    do_instr(5, 8'hEA, 1, 1, 1, 0, 1, 1, 0);
    do_instr(5, 8'hEA, 1, 1, 0, 1, 0, 0, 0);
    // randomized traffic
    nmi_cur = 1'b1;
    for (int k = 0; k < 80; k++) begin
      logic [7:0] pd;
      pd = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
      if ($urandom_range(0, 3) == 0) nmi_cur = ~nmi_cur;
      do_instr($urandom_range(5, 7), pd, nmi_cur, 1'($urandom), 1'($urandom),
               ($urandom_range(0, 3) == 0), 1'($urandom), 1'($urandom), 0);
    end
    tick(3'd1, 3'd2, 8'hEA, 1'b0);
    tick(3'd2, 3'd3, 8'hEA, 1'b0);
    check("seq_q_left", seq_q.size(), 0);
    check("bnd_q_left", bnd_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/interrupt_sequencer.md
Name: interrupt_sequencer

Overview:
- Upstream neighbour of the instruction/cycle controller. Produces `int_flag`, which forces BRK (0x00) into IR at the next T1.
- Arbitrates reset, NMI (edge), IRQ (level, I-masked) and software BRK.
- Supplies the vector low address, pushed-B value, stack-write suppression and PC-increment inhibit to the execution datapath for the shared BRK microsequence.

Parameters:
- SYNC_STAGES, 2, number of clk_ph1 synchroniser flops on `nmi_n`/`irq_n` (allowed range 1..3).

Ports:
- clk_ph1  in  1  clock phase 1; all state updates on its rising edge
- rst  in  1  synchronous, active-low reset
- nmi_n  in  1  async NMI request, falling-edge sensitive
- irq_n  in  1  async IRQ request, level-sensitive, active low
- i_flag  in  1  processor status I bit (1 = IRQ masked)
- PD  in  8  pre-decode register (opcode about to enter IR)
- cycle  in  3  current instruction cycle from cycle controller
- next_cycle  in  3  next instruction cycle from cycle controller
- vec_fetch  in  1  decode strobe: current cycle reads vector low byte
- int_flag  out  1  hardware interrupt/reset pending; cycle controller loads BRK at next T1
- vec_addr_lo  out  8  vector low address: 0xFC reset, 0xFA NMI, 0xFE IRQ/BRK
- b_push  out  1  B bit for the pushed status (1 only for software BRK)
- wr_suppress  out  1  stack pushes become reads (reset sequence)
- pc_inc_inh  out  1  inhibit PC increment at T1/T2 (hardware interrupt or reset)
- seq_active  out  1  a BRK-class sequence (any source) is in progress

Behaviour:
- Reset (rst==0 at edge):
  - Clears synchronisers to 1 and nmi_pend=0.
  - Sets reset_pend=1, int_flag=1, state=IDLE, src=RESET.
  - Outputs: vec_addr_lo=0xFC, b_push=0, wr_suppress=1, pc_inc_inh=1, seq_active=0.
  - Reset mid-sequence abandons all state; no partial outputs are held.
- Synchronisers: nmi_s/irq_s pass through SYNC_STAGES flops.
- NMI edge detect:
  - nmi_pend sets when prev nmi_s==1 and nmi_s==0.
  - It clears only on vec_fetch while the selected vector is NMI.
  - An edge in the same cycle as that clear wins; pend stays 1.
  - A held-low NMI does not re-trigger.
- irq_req = ~irq_s & ~i_flag (combinational, not latched).
- Poll, on each edge where next_cycle!=1 and state==IDLE:
  - int_flag <= reset_pend | nmi_pend | irq_req.
  - When next_cycle==1, int_flag holds, so the cycle controller sees a value that is stable across the T1 load.
- State machine IDLE -> SEQ -> IDLE:
  - IDLE->SEQ, on the edge with next_cycle==1, when int_flag==1 or PD==0x00. Source latched with priority:
    - reset_pend: src=RESET
    - else int_flag&nmi_pend: src=NMI
    - else int_flag: src=IRQ
    - else src=BRK
  - In SEQ, int_flag is held 0.
  - SEQ: vec_addr_lo follows src (BRK and IRQ both give 0xFE).
    - b_push = (src==BRK).
    - wr_suppress = (src==RESET).
    - pc_inc_inh = (src!=BRK).
    - seq_active = 1.
  - SEQ->IDLE on vec_fetch; reset_pend clears on that edge if src==RESET.
  - In IDLE the outputs return to 0xFE/0/0/0/0.
- Late IRQ: IRQ deasserting after poll but before T1 is ignored; the IRQ sequence still runs and uses 0xFE.
- Simultaneous events:
  - NMI edge and IRQ in the same poll: NMI wins; IRQ is re-evaluated after the sequence (normally masked by then, since the CPU sets I).
  - BRK opcode with int_flag=1: hardware source wins and b_push=0; the BRK is re-fetched later because the PC is not incremented.
- cycle is used only to qualify vec_fetch: a vec_fetch with cycle==0 or 1 is ignored.

Optional Feature:
- Macro `NMI_HIJACK_EN`.
- Defined: in SEQ with src IRQ or BRK, an nmi_pend observed before vec_fetch switches vec_addr_lo to 0xFA. That vec_fetch clears nmi_pend. b_push keeps the original src value.
- Undefined: the vector is fixed at SEQ entry; nmi_pend stays set and is serviced at the next poll.

Test Plan:
- Reset: rst=0 for 2 clocks, then 1. Expect int_flag=1 before the first T1, then SEQ with src=RESET: vec_addr_lo=0xFC, wr_suppress=1, pc_inc_inh=1. After vec_fetch: IDLE, int_flag=0, reset_pend=0.
- IRQ masking: irq_n=0, i_flag=1 through 3 instructions -> int_flag=0. Drop i_flag to 0 -> int_flag=1 by the next T1; SEQ gives vec_addr_lo=0xFE, b_push=0, pc_inc_inh=1.
- NMI edge: nmi_n 1->0, held low for 20 cycles -> exactly one sequence with vec_addr_lo=0xFA; nmi_pend clears at vec_fetch; no second sequence.
- Software BRK: PD=0x00, no requests -> SEQ with vec_addr_lo=0xFE, b_push=1, pc_inc_inh=0, wr_suppress=0.
- NMI+IRQ in the same poll -> src=NMI (0xFA). With i_flag still 0 afterwards, an IRQ sequence (0xFE) follows.
- With `NMI_HIJACK_EN`: PD=0x00 BRK, NMI edge 2 cycles before vec_fetch -> vec_addr_lo=0xFA, b_push=1, nmi_pend cleared. Without the macro -> vec_addr_lo=0xFE and an NMI sequence follows.
